// File: rtl/inner_prod_frame_accum.sv
// Frame accumulator: sums N signed inner products per frame and presents the sum on a valid/ready port.
// Optional saturation of the output sum is enabled by defining INNER_PROD_FRAME_ACCUM_SAT_EN.
module inner_prod_frame_accum #(
    parameter int DW    = 32,
    parameter int LEN_W = 8,
    parameter int OUT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_sync_rst,
    input  logic signed [DW-1:0]    i_inner_prod,
    input  logic                    i_inner_prod_valid,
    input  logic [LEN_W-1:0]        i_frame_len,
    output logic signed [OUT_W-1:0] o_sum,
    output logic                    o_sum_valid,
    input  logic                    i_sum_ready,
    output logic [15:0]             o_drop_cnt,
    output logic                    o_busy
);

    localparam int AW = DW + LEN_W;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t                  state_reg;
    logic signed [AW-1:0]    acc_reg;
    logic [LEN_W-1:0]        cnt_reg;
    logic [LEN_W-1:0]        nlen_reg;
    logic signed [OUT_W-1:0] sum_reg;
    logic                    sum_valid_reg;
    logic [15:0]             drop_cnt_reg;

    logic signed [AW-1:0]    sample_ext;
    logic signed [AW-1:0]    acc_next;
    logic signed [OUT_W-1:0] sum_next;
    logic [LEN_W-1:0]        start_len;
    logic [LEN_W-1:0]        cnt_inc;
    logic                    handshake;
    logic                    frame_start;

    assign sample_ext  = {{LEN_W{i_inner_prod[DW-1]}}, i_inner_prod};
    assign start_len   = (i_frame_len == '0) ? LEN_W'(1) : i_frame_len;
    assign cnt_inc     = cnt_reg + 1'b1;
    assign handshake   = (state_reg == HOLD) && i_sum_ready;
    // A sample arriving on the handshake cycle opens the next frame instead of being dropped
    assign frame_start = i_inner_prod_valid && ((state_reg == IDLE) || handshake);

`ifdef INNER_PROD_FRAME_ACCUM_SAT_EN
    localparam logic signed [AW-1:0]    SAT_MAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0]    SAT_MIN = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    always_comb begin
        acc_next = frame_start ? sample_ext : acc_reg + sample_ext;
`ifdef INNER_PROD_FRAME_ACCUM_SAT_EN
        if (acc_next > SAT_MAX) begin
            sum_next = OUT_MAX;
        end else if (acc_next < SAT_MIN) begin
            sum_next = OUT_MIN;
        end else begin
            sum_next = acc_next[OUT_W-1:0];
        end
`else
        sum_next = acc_next[OUT_W-1:0];
`endif
    end

`ifndef INNER_PROD_FRAME_ACCUM_SAT_EN
    // Wrapping conversion deliberately discards the accumulator's upper bits
    generate
        if (OUT_W < AW) begin : g_wrap_unused
            logic unused_hi;
            assign unused_hi = ^acc_next[AW-1:OUT_W];
        end
    endgenerate
`endif

    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            nlen_reg      <= '0;
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
            drop_cnt_reg  <= '0;
        end else begin
            if (frame_start) begin
                acc_reg  <= acc_next;
                cnt_reg  <= LEN_W'(1);
                nlen_reg <= start_len;
                if (start_len == LEN_W'(1)) begin
                    state_reg     <= HOLD;
                    sum_reg       <= sum_next;
                    sum_valid_reg <= 1'b1;
                end else begin
                    state_reg     <= ACCUM;
                    sum_valid_reg <= 1'b0;
                end
            end else begin
                case (state_reg)
                    ACCUM: begin
                        if (i_inner_prod_valid) begin
                            acc_reg <= acc_next;
                            cnt_reg <= cnt_inc;
                            if (cnt_inc == nlen_reg) begin
                                state_reg     <= HOLD;
                                sum_reg       <= sum_next;
                                sum_valid_reg <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (handshake) begin
                            state_reg     <= IDLE;
                            sum_valid_reg <= 1'b0;
                        end else if (i_inner_prod_valid && (drop_cnt_reg != 16'hFFFF)) begin
                            drop_cnt_reg <= drop_cnt_reg + 16'd1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_sum       = sum_reg;
    assign o_sum_valid = sum_valid_reg;
    assign o_drop_cnt  = drop_cnt_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule
